// File: rtl/fsm_mem_fill_param_if.sv
// rtl/fsm_mem_fill_param_if.sv - request and RAM write-port bundle for the fill sequencer
interface fsm_mem_fill_param_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] pattern;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              abort;
  logic              wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              finish;

  modport master (
    output start, mode, pattern, base_addr, length, abort,
    input  wr_en, mem_addr, wr_data, busy, finish
  );

  modport slave (
    input  start, mode, pattern, base_addr, length, abort,
    output wr_en, mem_addr, wr_data, busy, finish
  );
endinterface

// File: rtl/fsm_mem_fill_param.sv
// rtl/fsm_mem_fill_param.sv - programmable-window RAM fill sequencer with abort
module fsm_mem_fill_param #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_mem_fill_param_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] L_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state, w_state_nx;
  logic [ADDR_W:0]   r_idx, w_idx_nx, r_len, w_len_nx;
  logic [1:0]        r_mode, w_mode_nx;
  logic [DATA_W-1:0] r_pattern, w_pattern_nx;
  logic [ADDR_W-1:0] r_base, w_base_nx;
  logic              r_wr_en, w_wr_en_nx, r_busy, w_busy_nx, r_finish, w_finish_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_data, w_data_nx;

  logic [ADDR_W:0]   w_len_clamped, w_op_len, w_op_idx, w_rem;
  logic [1:0]        w_op_mode;
  logic [DATA_W-1:0] w_op_pattern, w_wdata;
  logic [ADDR_W-1:0] w_op_base, w_waddr;

  assign w_len_clamped = bus.length[ADDR_W] ? L_MAX : bus.length;

  // In IDLE the first write is built straight from the inputs so it can be registered at the start edge.
  assign w_op_mode    = (r_state == IDLE) ? bus.mode      : r_mode;
  assign w_op_pattern = (r_state == IDLE) ? bus.pattern   : r_pattern;
  assign w_op_base    = (r_state == IDLE) ? bus.base_addr : r_base;
  assign w_op_len     = (r_state == IDLE) ? w_len_clamped : r_len;
  assign w_op_idx     = (r_state == IDLE) ? '0            : r_idx;

  always_comb begin
    w_rem   = w_op_len - w_op_idx - IDX_ONE;
    w_waddr = w_op_base + ADDR_W'(w_op_idx);
    case (w_op_mode)
      2'b00:   w_wdata = DATA_W'(w_op_idx);
      2'b01:   w_wdata = w_op_pattern;
      2'b10:   w_wdata = DATA_W'(w_rem);
      default: w_wdata = DATA_W'(w_op_idx) ^ w_op_pattern;
    endcase
  end

  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_len_nx     = r_len;
    w_mode_nx    = r_mode;
    w_pattern_nx = r_pattern;
    w_base_nx    = r_base;
    w_wr_en_nx   = 1'b0;
    w_addr_nx    = r_addr;
    w_data_nx    = r_data;
    w_busy_nx    = 1'b0;
    w_finish_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_mode_nx    = bus.mode;
          w_pattern_nx = bus.pattern;
          w_base_nx    = bus.base_addr;
          w_len_nx     = w_len_clamped;
          w_busy_nx    = 1'b1;
          if (w_len_clamped == '0) begin
            w_state_nx  = DONE;
            w_idx_nx    = '0;
            w_finish_nx = 1'b1;
          end else begin
            w_state_nx = WRITE;
            w_idx_nx   = IDX_ONE;
            w_wr_en_nx = 1'b1;
            w_addr_nx  = w_waddr;
            w_data_nx  = w_wdata;
          end
        end
      end
      WRITE: begin
        // r_idx counts writes already presented; abort outranks the final write.
        if (bus.abort) begin
          w_state_nx = IDLE;
        end else if (r_idx == r_len) begin
          w_state_nx  = DONE;
          w_busy_nx   = 1'b1;
          w_finish_nx = 1'b1;
        end else begin
          w_idx_nx   = r_idx + IDX_ONE;
          w_wr_en_nx = 1'b1;
          w_busy_nx  = 1'b1;
          w_addr_nx  = w_waddr;
          w_data_nx  = w_wdata;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_mode    <= '0;
      r_pattern <= '0;
      r_base    <= '0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_len     <= w_len_nx;
      r_mode    <= w_mode_nx;
      r_pattern <= w_pattern_nx;
      r_base    <= w_base_nx;
      r_wr_en   <= w_wr_en_nx;
      r_addr    <= w_addr_nx;
      r_data    <= w_data_nx;
      r_busy    <= w_busy_nx;
      r_finish  <= w_finish_nx;
    end
  end

  assign bus.wr_en    = r_wr_en;
  assign bus.mem_addr = r_addr;
  assign bus.wr_data  = r_data;
  assign bus.busy     = r_busy;
  assign bus.finish   = r_finish;
endmodule

// File: tb/tb_fsm_mem_fill_param.sv
// tb/tb_fsm_mem_fill_param.sv - directed vector bench for fsm_mem_fill_param
module tb_fsm_mem_fill_param;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fsm_mem_fill_param_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  fsm_mem_fill_param #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic [7:0]       pat;
    logic [7:0]       base;
    logic [8:0]       len;
    bit               ab;
    int               n;
    logic [0:4][7:0]  ea;
    logic [0:4][7:0]  ed;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] exp_a [256];
  logic [7:0] exp_d [256];
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Start a fill, then check every cycle up to one past DONE; a start is also offered in DONE.
  task automatic run_fill(input logic [1:0] m, input logic [7:0] p, input logic [7:0] b,
                          input logic [8:0] l, input bit ab, input int n);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.pattern = p; bus.base_addr = b; bus.length = l;
    bus.abort = ab;
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.mode = 2'($urandom); bus.pattern = 8'($urandom);
        bus.base_addr = 8'($urandom); bus.length = 9'($urandom);
      end
      chk("wr_en",  {31'd0, bus.wr_en},  {31'd0, c <= n});
      chk("busy",   {31'd0, bus.busy},   {31'd0, c <= n + 1});
      chk("finish", {31'd0, bus.finish}, {31'd0, c == n + 1});
      if (c <= n) begin
        chk("mem_addr", {24'd0, bus.mem_addr}, {24'd0, exp_a[c-1]});
        chk("wr_data",  {24'd0, bus.wr_data},  {24'd0, exp_d[c-1]});
      end
      bus.start = (c == n + 1);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.mode = 2'b00; bus.pattern = 8'h00;
    bus.base_addr = 8'h00; bus.length = 9'd256; bus.abort = 1'b0;

    tbl[0] = '{2'b01, 8'hA5, 8'hFE, 9'd4, 1'b0, 4,
               {8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00}, {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00}};
    tbl[1] = '{2'b10, 8'h00, 8'h10, 9'd5, 1'b0, 5,
               {8'h10, 8'h11, 8'h12, 8'h13, 8'h14}, {8'h04, 8'h03, 8'h02, 8'h01, 8'h00}};
    tbl[2] = '{2'b11, 8'h0F, 8'h00, 9'd3, 1'b0, 3,
               {8'h00, 8'h01, 8'h02, 8'h00, 8'h00}, {8'h0F, 8'h0E, 8'h0D, 8'h00, 8'h00}};
    tbl[3] = '{2'b00, 8'h33, 8'h80, 9'd2, 1'b1, 2,
               {8'h80, 8'h81, 8'h00, 8'h00, 8'h00}, {8'h00, 8'h01, 8'h00, 8'h00, 8'h00}};
    tbl[4] = '{2'b01, 8'h77, 8'h05, 9'd0, 1'b0, 0,
               {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[5] = '{2'b10, 8'h00, 8'hFF, 9'd3, 1'b0, 3,
               {8'hFF, 8'h00, 8'h01, 8'h00, 8'h00}, {8'h02, 8'h01, 8'h00, 8'h00, 8'h00}};

    @(posedge clk);
    #1;
    chk("rst wr_en",  {31'd0, bus.wr_en},  32'd0);
    chk("rst busy",   {31'd0, bus.busy},   32'd0);
    chk("rst finish", {31'd0, bus.finish}, 32'd0);
    chk("rst addr",   {24'd0, bus.mem_addr}, 32'd0);
    chk("rst data",   {24'd0, bus.wr_data},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Legacy identity fill, then a clamped over-length request.
    for (int i = 0; i < 256; i++) begin exp_a[i] = 8'(i); exp_d[i] = 8'(i); end
    run_fill(2'b00, 8'h00, 8'h00, 9'd256, 1'b0, 256);
    run_fill(2'b00, 8'h00, 8'h00, 9'd300, 1'b0, 256);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 5; i++) begin exp_a[i] = tbl[v].ea[i]; exp_d[i] = tbl[v].ed[i]; end
      run_fill(tbl[v].mode, tbl[v].pat, tbl[v].base, tbl[v].len, tbl[v].ab, tbl[v].n);
    end

    // Abort on the third write, with an ignored start while busy.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.pattern = 8'h00; bus.base_addr = 8'h20; bus.length = 9'd10;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ab w1 addr", {24'd0, bus.mem_addr}, 32'h20);
    @(negedge clk);
    chk("ab w2 addr", {24'd0, bus.mem_addr}, 32'h21);
    bus.start = 1'b1; bus.base_addr = 8'h90; bus.mode = 2'b01;
    @(negedge clk);
    chk("ab w3 wr_en", {31'd0, bus.wr_en}, 32'd1);
    chk("ab w3 addr", {24'd0, bus.mem_addr}, 32'h22);
    chk("ab w3 data", {24'd0, bus.wr_data},  32'h02);
    bus.start = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("ab wr_en", {31'd0, bus.wr_en},  32'd0);
    chk("ab busy",  {31'd0, bus.busy},   32'd0);
    chk("ab finish", {31'd0, bus.finish}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab idle wr_en",  {31'd0, bus.wr_en},  32'd0);
      chk("ab idle finish", {31'd0, bus.finish}, 32'd0);
    end

    // Asynchronous reset in the middle of a fill.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.base_addr = 8'h40; bus.length = 9'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-rst wr_en", {31'd0, bus.wr_en}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid-rst wr_en",  {31'd0, bus.wr_en},  32'd0);
    chk("mid-rst busy",   {31'd0, bus.busy},   32'd0);
    chk("mid-rst finish", {31'd0, bus.finish}, 32'd0);
    chk("mid-rst addr",   {24'd0, bus.mem_addr}, 32'd0);
    chk("mid-rst data",   {24'd0, bus.wr_data},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post-rst wr_en",  {31'd0, bus.wr_en},  32'd0);
      chk("post-rst finish", {31'd0, bus.finish}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin exp_a[i] = 8'h40 + 8'(i); exp_d[i] = 8'(i); end
    run_fill(2'b00, 8'h00, 8'h40, 9'd3, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
